// File: rtl/edge_level_rebuilder.sv
// Rebuilds a level waveform from rise/fall event pulses, measures high widths and flags stream errors.
// Define EDGE_REBUILD_LOW_MEAS_EN to also measure low widths (low_len / low_valid).
module edge_level_rebuilder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rise_pulse,
  input  logic             fall_pulse,
  input  logic             err_clr,
  output logic             level_out,
  output logic [CNT_W-1:0] high_len,
  output logic             len_valid,
  output logic             err_dup_rise,
  output logic             err_dup_fall,
`ifdef EDGE_REBUILD_LOW_MEAS_EN
  output logic             err_both,
  output logic [CNT_W-1:0] low_len,
  output logic             low_valid
`else
  output logic             err_both
`endif
);

  typedef enum logic [1:0] {S_LOW, S_HIGH, S_ERR} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, high_len_d;
  logic             len_valid_d, dup_rise_d, dup_fall_d, both_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    high_len_d  = high_len;
    len_valid_d = 1'b0;
    dup_rise_d  = err_dup_rise;
    dup_fall_d  = err_dup_fall;
    both_d      = err_both;
    if (err_clr) begin
      // clear beats any pulse sampled in the same cycle
      state_d    = S_LOW;
      cnt_d      = '0;
      dup_rise_d = 1'b0;
      dup_fall_d = 1'b0;
      both_d     = 1'b0;
    end else begin
      case (state_q)
        S_LOW: begin
          if (rise_pulse && fall_pulse) begin
            state_d = S_ERR;
            both_d  = 1'b1;
          end else if (rise_pulse) begin
            state_d = S_HIGH;
            cnt_d   = CNT_ONE;
          end else if (fall_pulse) begin
            state_d    = S_ERR;
            dup_fall_d = 1'b1;
          end
        end
        S_HIGH: begin
          if (rise_pulse && fall_pulse) begin
            state_d = S_ERR;
            both_d  = 1'b1;
          end else if (rise_pulse) begin
            state_d    = S_ERR;
            dup_rise_d = 1'b1;
          end else if (fall_pulse) begin
            state_d     = S_LOW;
            high_len_d  = cnt_q;
            len_valid_d = 1'b1;
            cnt_d       = '0;
          end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: ;
      endcase
    end
    if (state_d == S_ERR) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_LOW;
      cnt_q        <= '0;
      level_out    <= 1'b0;
      high_len     <= '0;
      len_valid    <= 1'b0;
      err_dup_rise <= 1'b0;
      err_dup_fall <= 1'b0;
      err_both     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      level_out    <= (state_d == S_HIGH);
      high_len     <= high_len_d;
      len_valid    <= len_valid_d;
      err_dup_rise <= dup_rise_d;
      err_dup_fall <= dup_fall_d;
      err_both     <= both_d;
    end
  end

`ifdef EDGE_REBUILD_LOW_MEAS_EN
  logic [CNT_W-1:0] low_cnt_q, low_cnt_d, low_len_d;
  logic             fall_seen_q, fall_seen_d, low_valid_d;

  always_comb begin
    low_cnt_d   = low_cnt_q;
    fall_seen_d = fall_seen_q;
    low_len_d   = low_len;
    low_valid_d = 1'b0;
    if (err_clr || state_d == S_ERR) begin
      low_cnt_d   = '0;
      fall_seen_d = 1'b0;
    end else if (state_q == S_LOW && state_d == S_HIGH) begin
      // the first low stretch after reset/clear has no defined start
      if (fall_seen_q) begin
        low_len_d   = low_cnt_q;
        low_valid_d = 1'b1;
      end
      low_cnt_d = '0;
    end else if (state_q == S_HIGH && state_d == S_LOW) begin
      low_cnt_d   = CNT_ONE;
      fall_seen_d = 1'b1;
    end else if (state_q == S_LOW && low_cnt_q != CNT_MAX) begin
      low_cnt_d = low_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      low_cnt_q   <= '0;
      fall_seen_q <= 1'b0;
      low_len     <= '0;
      low_valid   <= 1'b0;
    end else begin
      low_cnt_q   <= low_cnt_d;
      fall_seen_q <= fall_seen_d;
      low_len     <= low_len_d;
      low_valid   <= low_valid_d;
    end
  end
`endif

endmodule
